ppu_pixel_sink: RTL



---
 rtl/ppu_pixel_sink_if.sv | 26 ++
 rtl/ppu_pixel_sink.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ppu_pixel_sink_if.sv
// rtl/ppu_pixel_sink_if.sv - PPU pixel stream in, framebuffer write port out, display status
interface ppu_pixel_sink_if;
  logic [1:0]  PX_IN;
  logic        PX_valid;
  logic [1:0]  PPU_MODE;
  logic [7:0]  LY;
  logic [7:0]  BGP;
  logic        LCD_EN;
  logic        FB_WE;
  logic [14:0] FB_ADDR;
  logic [1:0]  FB_DATA;
  logic        FB_READY;
  logic        LINE_DONE;
  logic        FRAME_DONE;
  logic        OVERFLOW;

  modport master (
    output PX_IN, PX_valid, PPU_MODE, LY, BGP, LCD_EN, FB_READY,
    input  FB_WE, FB_ADDR, FB_DATA, LINE_DONE, FRAME_DONE, OVERFLOW
  );

  modport slave (
    input  PX_IN, PX_valid, PPU_MODE, LY, BGP, LCD_EN, FB_READY,
    output FB_WE, FB_ADDR, FB_DATA, LINE_DONE, FRAME_DONE, OVERFLOW
  );
endinterface

// File: rtl/ppu_pixel_sink.sv
// rtl/ppu_pixel_sink.sv - palette-maps PPU pixels, queues them for the framebuffer, flags line/frame end
module ppu_pixel_sink #(
  parameter int LCD_W      = 160,
  parameter int LCD_H      = 144,
  parameter int FIFO_DEPTH = 8
) (
  input logic            clk,
  input logic            rst,
  ppu_pixel_sink_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  W8   = 8'(LCD_W);
  localparam logic [7:0]  H8   = 8'(LCD_H);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  logic [1:0]    prev_mode;
  logic [7:0]    x, y;
  logic          line_pending, line_done, frame_done, overflow;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  logic          draw_entry, line_end, frame_entry;
  logic [7:0]    x_eff, y_eff, x_next;
  logic          fb_we, pop, in_window, x_room, push, drop, full;
  logic [AW:0]   count_next;
  logic          line_pending_next, line_done_next;
  logic [14:0]   addr;
  logic [1:0]    shade;

  always_comb begin
    draw_entry  = (bus.PPU_MODE == 2'd3) && (prev_mode != 2'd3);
    line_end    = (bus.PPU_MODE == 2'd0) && (prev_mode == 2'd3);
    frame_entry = (bus.PPU_MODE == 2'd1) && (prev_mode != 2'd1);

    // A pixel arriving on the DRAW entry cycle already belongs to the new line.
    x_eff = draw_entry ? 8'd0 : x;
    y_eff = draw_entry ? bus.LY : y;

    fb_we     = (count != '0);
    full      = (count == FULL);
    pop       = fb_we && bus.FB_READY;
    in_window = bus.PX_valid && (bus.PPU_MODE == 2'd3) && bus.LCD_EN && (y_eff < H8);
    x_room    = (x_eff < W8);
    push      = in_window && x_room && (!full || pop);
    drop      = in_window && (!x_room || (full && !pop));

    if (!bus.LCD_EN)
      x_next = 8'd0;
    else if (in_window && x_room)
      x_next = x_eff + 8'd1;
    else
      x_next = x_eff;

    if (!bus.LCD_EN)
      count_next = '0;
    else if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
    else
      count_next = count;

    // LINE_DONE is high in the first cycle where a line is pending and the queue is empty.
    if (!bus.LCD_EN)
      line_pending_next = 1'b0;
    else if (line_end)
      line_pending_next = 1'b1;
    else if (line_done)
      line_pending_next = 1'b0;
    else
      line_pending_next = line_pending;
    line_done_next = bus.LCD_EN && line_pending_next && (count_next == '0);

    addr  = {y_eff, 7'b0} + {2'b0, y_eff, 5'b0} + {7'b0, x_eff};
    shade = bus.BGP[{bus.PX_IN, 1'b0} +: 2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_mode    <= 2'd0;
      x            <= 8'd0;
      y            <= 8'd0;
      line_pending <= 1'b0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      prev_mode    <= bus.PPU_MODE;
      x            <= x_next;
      y            <= !bus.LCD_EN ? 8'd0 : (draw_entry ? bus.LY : y);
      line_pending <= line_pending_next;
      line_done    <= line_done_next;
      frame_done   <= bus.LCD_EN && frame_entry;
      overflow     <= bus.LCD_EN && (overflow || drop);
      count        <= count_next;
      if (!bus.LCD_EN) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {addr, shade};
  end

  // Head fields are gated so an empty queue presents zeros rather than stale storage.
  assign bus.FB_WE      = fb_we;
  assign bus.FB_ADDR    = fb_we ? mem[rd_ptr][16:2] : 15'd0;
  assign bus.FB_DATA    = fb_we ? mem[rd_ptr][1:0] : 2'd0;
  assign bus.LINE_DONE  = line_done;
  assign bus.FRAME_DONE = frame_done;
  assign bus.OVERFLOW   = overflow;
endmodule
